// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory controller and its lane aligner.
package mem_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Bit positions of the memory controls inside the EX/MEM control field
   localparam int CTL_EN      = 0;
   localparam int CTL_SE      = 3;
   localparam int CTL_RW      = 4;
   localparam int CTL_SIZE_LO = 5;
   localparam int CTL_SIZE_HI = 6;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Reserved size 2'b11 is always treated as misaligned so it never reaches memory.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr_lo[0];
         SZ_WORD: return addr_lo != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/ack bus between the MEM-stage controller and data memory.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [3:0]        dm_byte_en;
   logic [31:0]       dm_wdata;
   logic              dm_ack;
   logic [31:0]       dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_byte_en, dm_wdata,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_byte_en, dm_wdata,
      output dm_ack, dm_rdata
   );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: lane enables, store-data replication, load extract/extend.
// Purely combinational so the instruction-fetch path can reuse it unchanged.
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        se,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);
   logic [31:0] shifted;

   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      byte_en   = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = shifted;
      case (size)
         SZ_BYTE: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{se & shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            byte_en   = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{se & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, pipeline stall, load return,
// misalignment and timeout flags.
//
//   state | meaning
//   IDLE  | no access outstanding; accepts aligned requests, flags misaligned ones
//   REQ   | dm_req held until dm_ack or timeout; pipeline stalled
//   DONE  | one retire cycle; load_valid / timeout_err pulse, new requests ignored
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_enable_in,
   input  logic              mem_rw_in,
   input  logic [1:0]        mem_size_in,
   input  logic              mem_se_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [31:0]       wdata_in,
   mem_access_ctrl_if.master dm,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              load_valid,
   output logic              misalign_err,
   output logic              timeout_err
);
   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic              accept;
   logic              misaligned;
   logic [CNT_W-1:0]  cnt;
   logic              rw_q;
   logic [1:0]        size_q;
   logic              se_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_ext;

   assign misaligned = is_misaligned(mem_size_in, addr_in[1:0]);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_enable_in && !misaligned) begin
               state_nxt = REQ;
               accept    = 1'b1;
            end
         end
         REQ: begin
            if (dm.dm_ack || cnt == '0) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Gated by reset so a still-asserted mem_enable_in cannot hold the pipe during reset.
   assign stall = reset & ((state == REQ) | accept);

   // The remaining-cycle timer counts down from TIMEOUT-1; expiry is terminal count 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         rw_q         <= 1'b0;
         size_q       <= 2'b00;
         se_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         load_data    <= '0;
         load_valid   <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_nxt;
         load_valid   <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  rw_q    <= mem_rw_in;
                  size_q  <= mem_size_in;
                  se_q    <= mem_se_in;
                  addr_q  <= addr_in;
                  wdata_q <= wdata_in;
                  cnt     <= CNT_LOAD;
               end else if (mem_enable_in) begin
                  misalign_err <= 1'b1;
               end
            end
            REQ: begin
               if (dm.dm_ack) begin
                  if (!rw_q) begin
                     load_data  <= rdata_ext;
                     load_valid <= 1'b1;
                  end
               end else if (cnt == '0) begin
                  timeout_err <= 1'b1;
                  load_data   <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   mem_lane_align u_lane_align (
      .addr_lo   (addr_q[1:0]),
      .size      (size_q),
      .se        (se_q),
      .wdata     (wdata_q),
      .rdata     (dm.dm_rdata),
      .byte_en   (dm.dm_byte_en),
      .wdata_rep (dm.dm_wdata),
      .rdata_ext (rdata_ext)
   );

   assign dm.dm_req  = (state == REQ);
   assign dm.dm_we   = rw_q;
   assign dm.dm_addr = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset/stray-ack
// sequence, then randomized accesses checked against a byte-level reference model.
module tb_mem_access_ctrl;
   localparam int TIMEOUT = 16;
   localparam int ADDR_W  = 32;

   typedef struct {
      logic        rw;
      logic [1:0]  size;
      logic        se;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_wait;
      logic [3:0]  be;
      logic [31:0] exp_wd;
      logic [31:0] exp_ld;
      logic        misal;
      int          stall_cycles;
   } vec_t;

   logic              clk;
   logic              reset;
   logic              mem_enable_in;
   logic              mem_rw_in;
   logic [1:0]        mem_size_in;
   logic              mem_se_in;
   logic [ADDR_W-1:0] addr_in;
   logic [31:0]       wdata_in;
   logic              stall;
   logic [31:0]       load_data;
   logic              load_valid;
   logic              misalign_err;
   logic              timeout_err;

   int vectors     = 0;
   int miscompares = 0;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W)) dm_bus ();

   mem_access_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_enable_in (mem_enable_in),
      .mem_rw_in     (mem_rw_in),
      .mem_size_in   (mem_size_in),
      .mem_se_in     (mem_se_in),
      .addr_in       (addr_in),
      .wdata_in      (wdata_in),
      .dm            (dm_bus.master),
      .stall         (stall),
      .load_data     (load_data),
      .load_valid    (load_valid),
      .misalign_err  (misalign_err),
      .timeout_err   (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic se,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int ack_wait,
                               input logic [3:0] be, input logic [31:0] exp_wd,
                               input logic [31:0] exp_ld, input logic misal,
                               input int stall_cycles);
      vec_t v;
      v.rw = rw; v.size = size; v.se = se; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.ack_wait = ack_wait; v.be = be; v.exp_wd = exp_wd;
      v.exp_ld = exp_ld; v.misal = misal; v.stall_cycles = stall_cycles;
      return v;
   endfunction

   // Reference model: works lane by lane on bytes rather than with shifts and masks.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      int          a;
      int          n;
      logic [7:0]  wb[4];
      logic [7:0]  rb[4];
      logic [31:0] val;
      r = v;
      a = int'(v.addr[1:0]);
      n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
      r.misal  = (v.size == 2'd3) || (a % n != 0);
      r.be     = '0;
      r.exp_wd = '0;
      r.exp_ld = '0;
      for (int i = 0; i < 4; i++) begin
         wb[i] = v.wdata[8*i +: 8];
         rb[i] = v.rdata[8*i +: 8];
      end
      if (!r.misal) begin
         for (int i = 0; i < n; i++) r.be[a+i] = 1'b1;
         for (int i = 0; i < 4; i++) r.exp_wd[8*i +: 8] = wb[i % n];
         val = '0;
         for (int i = 0; i < n; i++) val[8*i +: 8] = rb[a+i];
         if (v.se && n < 4 && rb[a+n-1][7])
            for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
         r.exp_ld = val;
      end
      r.stall_cycles = ((v.ack_wait < TIMEOUT - 1) ? v.ack_wait : TIMEOUT - 1) + 2;
      return r;
   endfunction

   // Runs one access from IDLE back to IDLE; ack_wait >= TIMEOUT means memory never answers.
   task automatic run_access(input vec_t v);
      int req_cycles;
      int stall_cnt;
      bit tmo;
      @(negedge clk);
      mem_enable_in = 1'b1;
      mem_rw_in     = v.rw;
      mem_size_in   = v.size;
      mem_se_in     = v.se;
      addr_in       = v.addr;
      wdata_in      = v.wdata;
      #1;
      chk("stall_accept", 32'(stall), 32'(!v.misal));
      chk("req_accept", 32'(dm_bus.dm_req), 32'd0);
      if (v.misal) begin
         @(negedge clk);
         #1;
         chk("misalign_pulse", 32'(misalign_err), 32'd1);
         chk("misalign_stall", 32'(stall), 32'd0);
         chk("misalign_req", 32'(dm_bus.dm_req), 32'd0);
         mem_enable_in = 1'b0;
         @(negedge clk);
         #1;
         chk("misalign_clear", 32'(misalign_err), 32'd0);
         chk("misalign_req2", 32'(dm_bus.dm_req), 32'd0);
         return;
      end
      stall_cnt  = stall ? 1 : 0;
      tmo        = (v.ack_wait >= TIMEOUT);
      req_cycles = tmo ? TIMEOUT : v.ack_wait + 1;
      for (int k = 0; k < req_cycles; k++) begin
         @(negedge clk);
         dm_bus.dm_ack   = (k == v.ack_wait);
         dm_bus.dm_rdata = (k == v.ack_wait) ? v.rdata : $urandom;
         #1;
         if (stall) stall_cnt++;
         chk("req_high", 32'(dm_bus.dm_req), 32'd1);
         chk("we", 32'(dm_bus.dm_we), 32'(v.rw));
         chk("addr", dm_bus.dm_addr, {v.addr[31:2], 2'b00});
         chk("byte_en", 32'(dm_bus.dm_byte_en), 32'(v.be));
         chk("wdata", dm_bus.dm_wdata, v.exp_wd);
      end
      @(negedge clk);
      dm_bus.dm_ack   = 1'b0;
      dm_bus.dm_rdata = $urandom;
      #1;
      chk("done_req", 32'(dm_bus.dm_req), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      chk("load_valid", 32'(load_valid), 32'(!v.rw && !tmo));
      chk("timeout_err", 32'(timeout_err), 32'(tmo));
      if (!v.rw || tmo) chk("load_data", load_data, tmo ? 32'd0 : v.exp_ld);
      chk("stall_cycles", 32'(stall_cnt), 32'(v.stall_cycles));
      @(negedge clk);
      mem_enable_in = 1'b0;
      #1;
      chk("idle_req", 32'(dm_bus.dm_req), 32'd0);
      chk("idle_valid", 32'(load_valid), 32'd0);
      chk("idle_tmo", 32'(timeout_err), 32'd0);
   endtask

   vec_t tbl[13];
   vec_t rv;

   initial begin
      tbl[0]  = mk(0, 2'd2, 0, 32'h100, 32'h11223344, 32'hDEADBEEF, 0,  4'b1111, 32'h11223344, 32'hDEADBEEF, 0, 2);
      tbl[1]  = mk(0, 2'd0, 1, 32'h203, 32'h000000A5, 32'h80FF1234, 1,  4'b1000, 32'hA5A5A5A5, 32'hFFFFFF80, 0, 3);
      tbl[2]  = mk(0, 2'd0, 0, 32'h203, 32'h000000A5, 32'h80FF1234, 0,  4'b1000, 32'hA5A5A5A5, 32'h00000080, 0, 2);
      tbl[3]  = mk(1, 2'd1, 0, 32'h042, 32'h0000ABCD, 32'h00000000, 3,  4'b1100, 32'hABCDABCD, 32'h00000000, 0, 5);
      tbl[4]  = mk(0, 2'd2, 0, 32'h102, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1, 0);
      tbl[5]  = mk(0, 2'd2, 0, 32'h300, 32'h0,        32'h12345678, 16, 4'b1111, 32'h0,        32'h0,        0, 17);
      tbl[6]  = mk(0, 2'd2, 0, 32'h304, 32'h0,        32'hCAFEF00D, 15, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 17);
      tbl[7]  = mk(0, 2'd1, 1, 32'h002, 32'h00005A5A, 32'h80010000, 0,  4'b1100, 32'h5A5A5A5A, 32'hFFFF8001, 0, 2);
      tbl[8]  = mk(1, 2'd0, 0, 32'h001, 32'h12345678, 32'h0,        2,  4'b0010, 32'h78787878, 32'h0,        0, 4);
      tbl[9]  = mk(0, 2'd3, 0, 32'h000, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1, 0);
      tbl[10] = mk(0, 2'd1, 0, 32'h001, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1, 0);
      tbl[11] = mk(0, 2'd1, 0, 32'h000, 32'h0,        32'h1234F00D, 1,  4'b0011, 32'h0,        32'h0000F00D, 0, 3);
      tbl[12] = mk(0, 2'd0, 1, 32'h001, 32'h0,        32'h00007F00, 0,  4'b0010, 32'h0,        32'h0000007F, 0, 2);

      reset           = 1'b0;
      mem_enable_in   = 1'b0;
      mem_rw_in       = 1'b0;
      mem_size_in     = 2'd0;
      mem_se_in       = 1'b0;
      addr_in         = '0;
      wdata_in        = '0;
      dm_bus.dm_ack   = 1'b0;
      dm_bus.dm_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req", 32'(dm_bus.dm_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_valid", 32'(load_valid), 32'd0);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      chk("rst_addr", dm_bus.dm_addr, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) run_access(tbl[i]);

      // Reset in the middle of REQ, then a stray ack while idle.
      @(negedge clk);
      mem_enable_in = 1'b1;
      mem_rw_in     = 1'b0;
      mem_size_in   = 2'd2;
      mem_se_in     = 1'b0;
      addr_in       = 32'h400;
      @(negedge clk);
      #1;
      chk("rstreq_req_before", 32'(dm_bus.dm_req), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rstreq_req_drop", 32'(dm_bus.dm_req), 32'd0);
      chk("rstreq_stall_drop", 32'(stall), 32'd0);
      @(negedge clk);
      #1;
      chk("rstreq_no_valid", 32'(load_valid), 32'd0);
      reset         = 1'b1;
      mem_enable_in = 1'b0;
      @(negedge clk);
      dm_bus.dm_ack   = 1'b1;
      dm_bus.dm_rdata = 32'h5555AAAA;
      #1;
      chk("stray_req", 32'(dm_bus.dm_req), 32'd0);
      chk("stray_stall", 32'(stall), 32'd0);
      @(negedge clk);
      dm_bus.dm_ack = 1'b0;
      #1;
      chk("stray_valid", 32'(load_valid), 32'd0);
      chk("stray_load_data", load_data, 32'd0);
      chk("stray_req2", 32'(dm_bus.dm_req), 32'd0);
      run_access(tbl[0]);

      for (int i = 0; i < 60; i++) begin
         rv.rw       = 1'($urandom_range(0, 1));
         rv.size     = 2'($urandom_range(0, 3));
         rv.se       = 1'($urandom_range(0, 1));
         rv.addr     = $urandom;
         rv.wdata    = $urandom;
         rv.rdata    = $urandom;
         rv.ack_wait = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18))
                                                   : int'($urandom_range(0, 4));
         run_access(model(rv));
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
